// File: rtl/oled_cmd_arbiter.sv
// Round-robin arbiter sharing one OLED driver command port.
// Optional watchdog abort: define OLED_ARB_WDOG_EN.
module oled_cmd_arbiter #(
    parameter int NREQ      = 3,
    parameter int CMD_W     = 88,
    parameter int TO_CYCLES = 4096
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NREQ-1:0]                          req,
    input  logic [NREQ*CMD_W-1:0]                    cmd_in,
    input  logic                                     rdy_oled,
    output logic                                     draw,
    output logic [CMD_W-1:0]                         oled_IR,
    output logic [NREQ-1:0]                          ack,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id,
    output logic                                     busy,
    output logic                                     timeout
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        WAIT_LOW,
        WAIT_HIGH,
        DONE
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     lg_d;
    logic [GW-1:0]     gid_d;
    logic [GW-1:0]     winner;
    logic [GW-1:0]     idx;
    logic              found;
    logic [CMD_W-1:0]  ir_d;
    logic              draw_d;
    logic [NREQ-1:0]   ack_d;
    logic [CMD_W-1:0]  cmds [NREQ];

`ifdef OLED_ARB_WDOG_EN
    localparam int CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    logic [CW-1:0]     wd_cnt;
    logic              wd_hit;
    logic              to_d;
`endif

    for (genvar i = 0; i < NREQ; i++) begin : g_cmd
        assign cmds[i] = cmd_in[i*CMD_W +: CMD_W];
    end

    assign busy = (state != IDLE);

    // Find the first requester after the previous winner, wrapping around
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = GW'((int'(last_grant) + k) % NREQ);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Next-state and next-output logic for one command transaction
    always_comb begin
        state_d = state;
        ir_d    = oled_IR;
        gid_d   = grant_id;
        lg_d    = last_grant;
        draw_d  = 1'b0;
        ack_d   = '0;
`ifdef OLED_ARB_WDOG_EN
        to_d    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (found && rdy_oled) begin
                    ir_d    = cmds[winner];
                    gid_d   = winner;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                draw_d  = 1'b1;
                state_d = STROBE;
            end
            STROBE: begin
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!rdy_oled) begin
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rdy_oled) begin
                    ack_d   = NREQ'(1) << grant_id;
                    lg_d    = grant_id;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef OLED_ARB_WDOG_EN
        // A completing handshake wins over a simultaneous watchdog expiry
        if (wd_hit && state_d != DONE &&
            (state == WAIT_LOW || state == WAIT_HIGH)) begin
            to_d    = 1'b1;
            lg_d    = grant_id;
            state_d = IDLE;
        end
`endif
    end

    // State and registered driver-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            oled_IR    <= '0;
            grant_id   <= '0;
            last_grant <= GW'(NREQ - 1);
            draw       <= 1'b0;
            ack        <= '0;
        end else begin
            state      <= state_d;
            oled_IR    <= ir_d;
            grant_id   <= gid_d;
            last_grant <= lg_d;
            draw       <= draw_d;
            ack        <= ack_d;
        end
    end

`ifdef OLED_ARB_WDOG_EN
    assign wd_hit = (wd_cnt == CW'(TO_CYCLES - 1));

    // Count cycles spent waiting on the driver handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == STROBE) begin
            wd_cnt <= '0;
        end else if (state == WAIT_LOW || state == WAIT_HIGH) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // One-cycle abort pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout <= 1'b0;
        end else begin
            timeout <= to_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_oled_cmd_arbiter.sv
// Randomised bench for oled_cmd_arbiter against a transaction-level model.
// Watchdog expectations follow OLED_ARB_WDOG_EN (TO_CYCLES = 8 here).
module tb_oled_cmd_arbiter;

    localparam int NREQ  = 3;
    localparam int CMD_W = 88;
    localparam int TO    = 8;
    localparam int GW    = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req;
    logic [NREQ*CMD_W-1:0]   cmd_in;
    logic                    rdy_oled;
    logic                    draw;
    logic [CMD_W-1:0]        oled_IR;
    logic [NREQ-1:0]         ack;
    logic [GW-1:0]           grant_id;
    logic                    busy;
    logic                    timeout;

    int n_chk  = 0;
    int n_fail = 0;
    int last_g;
    int w;
    logic [CMD_W-1:0] cmds [NREQ];
    logic [CMD_W-1:0] lit;
    int fair [6] = '{0, 1, 2, 0, 1, 2};
    int held [3] = '{1, 0, 1};

    oled_cmd_arbiter #(
        .NREQ      (NREQ),
        .CMD_W     (CMD_W),
        .TO_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .cmd_in   (cmd_in),
        .rdy_oled (rdy_oled),
        .draw     (draw),
        .oled_IR  (oled_IR),
        .ack      (ack),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CMD_W-1:0] rnd_cmd();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[CMD_W-1:0];
    endfunction

    task automatic set_cmd(input int i, input logic [CMD_W-1:0] v);
        cmds[i] = v;
        cmd_in[i*CMD_W +: CMD_W] = v;
    endtask

    // Winner = requesting index at the smallest rotational distance past last
    function automatic int pick(input int last, input logic [NREQ-1:0] r);
        int best = -1;
        int bd   = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (r[i]) begin
                int d = (i - last - 1 + NREQ) % NREQ;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    // Starts at an IDLE negedge with req/rdy settled; ends at the WAIT_LOW negedge
    task automatic start_grant(output int win, input bit mess);
        logic [CMD_W-1:0] ecmd;
        chk("idle_busy", busy, 1'b0);
        win  = pick(last_g, req);
        ecmd = cmds[win];
        @(negedge clk);
        chk("grant_id", grant_id, win);
        chk("oled_ir", oled_IR, ecmd);
        chk("load_draw", draw, 1'b0);
        chk("load_busy", busy, 1'b1);
        chk("load_timeout", timeout, 1'b0);
        if (mess) begin
            if ($urandom_range(0, 1) == 1) req[win] = 1'b0;
            if ($urandom_range(0, 1) == 1) set_cmd(win, rnd_cmd());
        end
        @(negedge clk);
        chk("draw_pulse", draw, 1'b1);
        chk("strobe_ack", ack, '0);
        chk("strobe_ir", oled_IR, ecmd);
        @(negedge clk);
        chk("draw_single", draw, 1'b0);
    endtask

    // Driver keeps rdy high dl cycles, low dh cycles, then ready; ends at DONE
    task automatic finish_txn(input int win, input int dl, input int dh);
        logic [NREQ-1:0] ea;
        for (int c = 0; c < dl + dh; c++) begin
            chk("quiet", {draw, ack}, '0);
            rdy_oled = (c < dl);
            @(negedge clk);
        end
        chk("quiet", {draw, ack}, '0);
        rdy_oled = 1'b1;
        @(negedge clk);
        ea      = '0;
        ea[win] = 1'b1;
        chk("ack", ack, ea);
        chk("done_busy", busy, 1'b1);
        chk("done_timeout", timeout, 1'b0);
        last_g = win;
    endtask

    task automatic txn(input bit mess, input int dl, input int dh,
                       output int win);
        start_grant(win, mess);
        finish_txn(win, dl, dh);
    endtask

    task automatic to_idle();
        @(negedge clk);
        chk("ack_pulse", ack, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        req      = '1;
        rdy_oled = 1'b1;
        cmd_in   = '0;
        last_g   = NREQ - 1;
        for (int i = 0; i < NREQ; i++) set_cmd(i, rnd_cmd());

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_draw", draw, 1'b0);
        chk("rst_ack", ack, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ir", oled_IR, '0);
        chk("rst_gid", grant_id, '0);
        chk("rst_timeout", timeout, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            txn(1'b0, $urandom_range(0, 2), $urandom_range(1, 4), w);
            chk("fair_seq", grant_id, fair[i]);
            req[w] = 1'b0;
            to_idle();
            req[w] = 1'b1;
        end

        lit = 88'h26_01_00_00_00_00_00_00_00_00_00;
        set_cmd(0, lit);
        req = 3'b001;
        txn(1'b0, 1, 5, w);
        chk("single_gid", grant_id, 0);
        chk("single_ir", oled_IR, lit);
        req = '0;
        to_idle();
        chk("ir_hold", oled_IR, lit);
        @(negedge clk);
        chk("no_req_idle", busy, 1'b0);

        req = 3'b010;
        for (int i = 0; i < 3; i++) begin
            txn(1'b0, $urandom_range(0, 2), $urandom_range(1, 3), w);
            chk("held_seq", grant_id, held[i]);
            req = 3'b011;
            to_idle();
        end

        req = '1;
        start_grant(w, 1'b0);
        rdy_oled = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        rst      = 1'b1;
        rdy_oled = 1'b1;
        @(negedge clk);
        chk("mid_rst_draw", draw, 1'b0);
        chk("mid_rst_ack", ack, '0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ir", oled_IR, '0);
        chk("mid_rst_gid", grant_id, '0);
        chk("mid_rst_timeout", timeout, 1'b0);
        rst    = 1'b0;
        req    = '1;
        last_g = NREQ - 1;
        txn(1'b0, 0, 2, w);
        chk("post_rst_gid", grant_id, 0);
        to_idle();

        start_grant(w, 1'b0);
        rdy_oled = 1'b0;
        for (int c = 0; c < TO; c++) begin
            chk("wd_wait", {ack, timeout}, '0);
            @(negedge clk);
        end
`ifdef OLED_ARB_WDOG_EN
        chk("wd_timeout", timeout, 1'b1);
        chk("wd_noack", ack, '0);
        chk("wd_idle", busy, 1'b0);
        last_g   = w;
        rdy_oled = 1'b1;
`else
        chk("wd_none", timeout, 1'b0);
        chk("wd_stuck", busy, 1'b1);
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            chk("wd_hang", {busy, ack, timeout}, {1'b1, 4'b0});
        end
        finish_txn(w, 0, 1);
        to_idle();
`endif
        txn(1'b0, 0, 1, w);
        chk("wd_next_gid", grant_id, 2);
        to_idle();

        for (int t = 0; t < 30; t++) begin
            int gap;
            req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            gap = $urandom_range(0, 2);
            if (gap > 0) rdy_oled = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("gap_idle", {busy, draw}, '0);
            end
            rdy_oled = 1'b1;
            txn(1'b1, $urandom_range(0, 3), $urandom_range(1, 6), w);
            to_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/oled_cmd_arbiter.md
Name: oled_cmd_arbiter

Overview:
Round-robin arbiter that shares the single OLED driver command port (88-bit command word plus draw strobe, gated by rdy_oled) between several command sources, such as the program executor, a scroll/refresh engine and a debug injector. For each granted request it latches the command, issues one draw pulse, tracks the driver's busy/ready cycle, and returns a one-cycle ack to the winner. It sits between the command sources and the OLED driver.

Parameters:
NREQ, 3, number of requesters (2..8)
CMD_W, 88, command word width
TO_CYCLES, 4096, watchdog limit in clk cycles (used only with OLED_ARB_WDOG_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req  in  NREQ  per-requester request; held high with cmd stable until ack
cmd_in  in  NREQ*CMD_W  packed commands; requester i occupies bits [i*CMD_W +: CMD_W]
rdy_oled  in  1  driver ready; low while the driver processes a command
draw  out  1  one-cycle command strobe to the driver
oled_IR  out  CMD_W  latched command presented to the driver
ack  out  NREQ  one-hot, one-cycle completion pulse
grant_id  out  max(1,$clog2(NREQ))  index of the current or last granted requester
busy  out  1  high in every state except IDLE
timeout  out  1  one-cycle watchdog abort pulse; constant 0 without the macro

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant = NREQ-1 (so requester 0 has first priority), watchdog counter 0. Reset is also taken mid-transaction; any in-flight command is dropped and no ack is issued.
- FSM states: IDLE, LOAD, STROBE, WAIT_LOW, WAIT_HIGH, DONE.
- IDLE: if (|req) && rdy_oled, pick the winner by searching from (last_grant+1) mod NREQ upward with wrap. At the clock edge: oled_IR <= winner's cmd, grant_id <= winner, go to LOAD. If rdy_oled is low, stay in IDLE.
- LOAD: draw <= 1, go to STROBE.
- STROBE: draw <= 0, go to WAIT_LOW. draw is high for exactly 1 cycle, the cycle after oled_IR updates.
- WAIT_LOW: wait for rdy_oled==0 (driver accepted), then go to WAIT_HIGH.
- WAIT_HIGH: wait for rdy_oled==1, then ack[grant_id] <= 1, last_grant <= grant_id, go to DONE.
- DONE: ack <= 0, go to IDLE. The earliest next grant is 1 cycle after DONE, which lets the requester drop req after seeing ack.
- Minimum latency: req seen in IDLE at cycle N gives draw at N+2 and ack at the earliest at N+5.
- oled_IR holds its value until the next grant; it is not cleared after completion.
- Simultaneous requests: exactly one grant per transaction, with strict rotation, so no requester waits more than NREQ-1 transactions.
- req dropped before grant: ignored. req dropped after grant: the transaction still completes and ack is still pulsed.
- req and cmd_in changes after latching have no effect on the current transaction.
- ack is never asserted for more than 1 cycle. draw is never re-asserted within a transaction.

Optional Feature:
Macro OLED_ARB_WDOG_EN.
- With the macro: a counter clears on entry to WAIT_LOW and increments in WAIT_LOW and WAIT_HIGH. When it reaches TO_CYCLES-1, the block pulses timeout for 1 cycle, issues no ack, sets last_grant <= grant_id (so the hung requester loses priority), and goes to IDLE.
- Without the macro: no counter is built, the block waits indefinitely, and timeout is tied to 0.

Test Plan:
- Reset: hold rst 2 cycles with req=3'b111 -> draw, ack, busy, oled_IR, grant_id, timeout all 0, and state IDLE after release.
- Single request: req=3'b001, cmd0=88'h26_01_00..00; driver model drops rdy_oled 2 cycles after draw and raises it 5 cycles later -> oled_IR=cmd0, draw is a single pulse 2 cycles after req, and ack=3'b001 for 1 cycle after rdy_oled returns.
- Fairness: req=3'b111 held, each requester re-raising req 1 cycle after its ack -> grant_id sequence 0,1,2,0,1,2 with no repeats.
- Held request: req1 held continuously while req0 is raised after the first grant -> grants alternate 1,0,1, and no requester gets two consecutive grants while the other is pending.
- Reset mid-transaction: assert rst during WAIT_HIGH -> next cycle all outputs are 0, no ack, and the next grant goes to requester 0.
- Watchdog: build with OLED_ARB_WDOG_EN and TO_CYCLES=8, driver keeps rdy_oled low -> timeout pulses at the 8th waiting cycle, no ack, and the next grant goes to the next requester. Without the macro, the same stimulus leaves the block in WAIT_HIGH.
